// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives instruction memory via req/valid and buffers
// fetched {pc, inst} pairs in a FIFO presented to decode through valid/ready.
module fetch_unit #(
  parameter int unsigned          WORD_LEN     = 32,
  parameter logic [WORD_LEN-1:0]  RESET_VECTOR = '0,
  parameter logic [WORD_LEN-1:0]  EXIT_INST    = WORD_LEN'(32'h34333231),
  parameter int unsigned          FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                memory_req,
  output logic [WORD_LEN-1:0] memory_addr,
  input  logic                memory_valid,
  input  logic [WORD_LEN-1:0] memory_inst,
  input  logic                redirect_valid,
  input  logic [WORD_LEN-1:0] redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [WORD_LEN-1:0] inst_data,
  output logic [WORD_LEN-1:0] inst_pc,
  output logic                exit
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WORD_LEN-1:0] pc_q, pc_nxt;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_nxt;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0]    count_q, count_nxt;
  logic                exit_q, exit_nxt;

  logic [WORD_LEN-1:0] buf_inst [FIFO_DEPTH];
  logic [WORD_LEN-1:0] buf_pc   [FIFO_DEPTH];

  logic xfer, pop, flush, is_exit, push;

  // Request depends only on registered state (and reset), never on inst_ready.
  assign memory_req  = ~rst & ~exit_q & (count_q < CNT_W'(FIFO_DEPTH));
  assign memory_addr = pc_q;
  assign inst_valid  = (count_q != '0);
  assign inst_data   = inst_valid ? buf_inst[rd_ptr_q] : '0;
  assign inst_pc     = inst_valid ? buf_pc[rd_ptr_q]   : '0;
  assign exit        = exit_q;

  assign xfer    = memory_req & memory_valid;
  assign pop     = inst_valid & inst_ready;
  assign flush   = redirect_valid & ~exit_q;
  assign is_exit = xfer & (memory_inst == EXIT_INST);
  assign push    = xfer & ~is_exit & ~flush;

  // Next-state: a redirect wins over any same-cycle transfer or pop.
  always_comb begin
    pc_nxt     = pc_q;
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    count_nxt  = count_q;
    exit_nxt   = exit_q;
    if (flush) begin
      pc_nxt     = redirect_pc & ~WORD_LEN'(3);
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) begin
        pc_nxt     = pc_q + WORD_LEN'(4);
        wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
      end
      if (is_exit) begin
        exit_nxt = 1'b1;
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
      end
      count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_VECTOR;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      exit_q   <= 1'b0;
    end else begin
      pc_q     <= pc_nxt;
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
      exit_q   <= exit_nxt;
    end
  end

  // Buffer storage needs no reset; visibility is governed by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_inst[wr_ptr_q] <= memory_inst;
      buf_pc[wr_ptr_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for fetch, backpressure, late memory,
// redirect and exit, plus hand sequences for async reset and reset-vector wrap.
module tb_fetch_unit;

  localparam logic [31:0] EXIT_WORD = 32'h34333231;
  localparam logic [31:0] EXIT_ADDR = 32'h0000_0108;

  logic        clk = 1'b0;
  logic        rst;
  logic        memory_req, memory_valid, redirect_valid, inst_valid, inst_ready, exit;
  logic [31:0] memory_addr, memory_inst, redirect_pc, inst_data, inst_pc;

  logic        memory_req2, inst_valid2, exit2;
  logic [31:0] memory_addr2, memory_inst2, inst_data2, inst_pc2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_0000;
  endfunction

  always_comb memory_inst  = (memory_addr == EXIT_ADDR) ? EXIT_WORD : mem_word(memory_addr);
  always_comb memory_inst2 = mem_word(memory_addr2);

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .memory_req(memory_req), .memory_addr(memory_addr),
    .memory_valid(memory_valid), .memory_inst(memory_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .exit(exit)
  );

  fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst),
    .memory_req(memory_req2), .memory_addr(memory_addr2),
    .memory_valid(1'b1), .memory_inst(memory_inst2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .inst_valid(inst_valid2), .inst_ready(1'b1),
    .inst_data(inst_data2), .inst_pc(inst_pc2), .exit(exit2)
  );

  typedef struct {
    logic        mv, rdy, rv;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
    logic        ex;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic mv, rdy, rv, input logic [31:0] rpc,
                              input logic req, input logic [31:0] addr,
                              input logic iv, input logic [31:0] ipc, input logic ex);
    vec_t v;
    v.mv = mv; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.req = req; v.addr = addr; v.iv = iv; v.ipc = ipc; v.ex = ex;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; memory_valid = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;

    // Expected outputs for each cycle, sampled before that cycle's rising edge.
    //   mv    rdy   rv    rpc           req   addr          iv    ipc           ex
    add(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h00,       1'b0, 32'h0,        1'b0); // c0
    add(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h04,       1'b1, 32'h00,       1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h08,       1'b1, 32'h04,       1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0C,       1'b1, 32'h08,       1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h10,       1'b1, 32'h0C,       1'b0); // c4 backpressure
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h14,       1'b1, 32'h0C,       1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h18,       1'b1, 32'h0C,       1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1C,       1'b1, 32'h0C,       1'b0); // full
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1C,       1'b1, 32'h0C,       1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h1C,       1'b1, 32'h0C,       1'b0); // pop C
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1C,       1'b1, 32'h10,       1'b0); // c10 late memory
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1C,       1'b1, 32'h10,       1'b0);
    add(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1C,       1'b1, 32'h10,       1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h1C,       1'b1, 32'h10,       1'b0);
    add(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h20,       1'b1, 32'h10,       1'b0); // c14
    add(1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h20,       1'b1, 32'h14,       1'b0);
    add(1'b1, 1'b1, 1'b1, 32'h103,      1'b1, 32'h20,       1'b1, 32'h18,       1'b0); // redirect
    add(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0,        1'b0);
    add(1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h104,      1'b1, 32'h100,      1'b0);
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h108,      1'b1, 32'h104,      1'b0); // exit word
    add(1'b1, 1'b0, 1'b1, 32'h200,      1'b0, 32'h108,      1'b1, 32'h104,      1'b1); // ignored redirect
    add(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h108,      1'b1, 32'h104,      1'b1);

    repeat (2) @(negedge clk);
    check("rst_req",   32'(memory_req), 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_data",  inst_data,       32'h0);
    check("rst_pc",    inst_pc,         32'h0);
    check("rst_exit",  32'(exit),       32'h0);

    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      memory_valid   = vq[i].mv;
      inst_ready     = vq[i].rdy;
      redirect_valid = vq[i].rv;
      redirect_pc    = vq[i].rpc;
      #1;
      check($sformatf("c%0d_req", i),   32'(memory_req), 32'(vq[i].req));
      check($sformatf("c%0d_addr", i),  memory_addr,     vq[i].addr);
      check($sformatf("c%0d_valid", i), 32'(inst_valid), 32'(vq[i].iv));
      check($sformatf("c%0d_exit", i),  32'(exit),       32'(vq[i].ex));
      if (vq[i].iv) begin
        check($sformatf("c%0d_ipc", i),  inst_pc,   vq[i].ipc);
        check($sformatf("c%0d_data", i), inst_data, mem_word(vq[i].ipc));
      end
      if (i == 0) begin
        check("wrap_addr0", memory_addr2,     32'hFFFF_FFFC);
        check("wrap_req0",  32'(memory_req2), 32'h1);
      end
      if (i == 1) begin
        check("wrap_addr1", memory_addr2,     32'h0);
        check("wrap_ipc1",  inst_pc2,         32'hFFFF_FFFC);
        check("wrap_data1", inst_data2,       mem_word(32'hFFFF_FFFC));
      end
      @(negedge clk);
    end

    // Async reset while halted with an entry buffered.
    redirect_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_exit",  32'(exit),       32'h0);
    check("arst_valid", 32'(inst_valid), 32'h0);
    check("arst_req",   32'(memory_req), 32'h0);
    @(negedge clk);
    rst = 1'b0; memory_valid = 1'b1; inst_ready = 1'b0;
    #1;
    check("restart_req",  32'(memory_req), 32'h1);
    check("restart_addr", memory_addr,     32'h0);
    repeat (3) @(negedge clk);
    #1;
    check("fill3_valid", 32'(inst_valid), 32'h1);
    check("fill3_pc",    inst_pc,         32'h0);
    check("fill3_addr",  memory_addr,     32'h0C);
    check("fill3_req",   32'(memory_req), 32'h1);

    // Async reset with three entries buffered and a request pending.
    memory_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst2_valid", 32'(inst_valid), 32'h0);
    check("arst2_req",   32'(memory_req), 32'h0);
    check("arst2_data",  inst_data,       32'h0);
    check("arst2_pc",    inst_pc,         32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("restart2_req",  32'(memory_req), 32'h1);
    check("restart2_addr", memory_addr,     32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
